alu_uart_if: RTL and testbench

//  Initiator side of the ALU: collects operand A, operand B and opcode as three successive

---
 rtl/alu_uart_if.sv | 160 ++++++++++++++++
 tb/tb_alu_uart_if.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_uart_if.sv
// alu_uart_if: initiator side of the ALU. It collects operand A, operand B and
// the opcode as three bytes from uart_rx, drives them onto the combinational
// ALU, captures the {carry,res} result and returns it through uart_tx.
//
// Optional feature macro: ALU_IF_CARRY_BYTE_EN
//   defined     -> two bytes per operation: the result LSBs, then {0..0,carry}
//   not defined -> only the result LSBs are returned and the carry is dropped
module alu_uart_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OPS  = 6
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OPS-1:0]  o_ops,
  input  logic [NB_DATA:0]   i_alu_res,
  output logic               o_busy
);

  typedef enum logic [2:0] {
    WAIT_A   = 3'd0,
    WAIT_B   = 3'd1,
    WAIT_OP  = 3'd2,
    EXEC     = 3'd3,
    START_LO = 3'd4,
    WAIT_LO  = 3'd5,
    START_HI = 3'd6,
    WAIT_HI  = 3'd7
  } state_t;

  state_t             state_q, state_d;
  logic [NB_DATA-1:0] dataA_q, dataA_d;
  logic [NB_DATA-1:0] dataB_q, dataB_d;
  logic [NB_OPS-1:0]  ops_q, ops_d;
  logic [NB_DATA:0]   res_q, res_d;
  logic               unusedRxBits;

  // Only the low NB_OPS bits of the opcode byte carry meaning; the upper
  // bits are deliberately discarded and collected here so that is explicit.
  assign unusedRxBits = ^i_rx_data[NB_DATA-1:NB_OPS];

  // State and data registers; reset clears everything and parks in WAIT_A.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= WAIT_A;
      dataA_q <= '0;
      dataB_q <= '0;
      ops_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      dataA_q <= dataA_d;
      dataB_q <= dataB_d;
      ops_q   <= ops_d;
      res_q   <= res_d;
    end
  end

  // Next-state and register-load decisions. Received bytes are only
  // accepted in the three collection states, so anything arriving while
  // busy falls through untouched. The operand registers are never cleared
  // after a transaction; they hold until the next byte for their slot.
  always_comb begin
    state_d = state_q;
    dataA_d = dataA_q;
    dataB_d = dataB_q;
    ops_d   = ops_q;
    res_d   = res_q;
    case (state_q)
      WAIT_A: begin
        if (i_rx_done) begin
          dataA_d = i_rx_data;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (i_rx_done) begin
          dataB_d = i_rx_data;
          state_d = WAIT_OP;
        end
      end
      WAIT_OP: begin
        if (i_rx_done) begin
          ops_d   = i_rx_data[NB_OPS-1:0];
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = i_alu_res;
        state_d = START_LO;
      end
      START_LO: begin
        state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (i_tx_done) begin
`ifdef ALU_IF_CARRY_BYTE_EN
          state_d = START_HI;
`else
          state_d = WAIT_A;
`endif
        end
      end
`ifdef ALU_IF_CARRY_BYTE_EN
      START_HI: begin
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (i_tx_done) begin
          state_d = WAIT_A;
        end
      end
`endif
      default: begin
        state_d = WAIT_A;
      end
    endcase
  end

  // Moore outputs decoded purely from the state: the start pulse exists only
  // in the START_* states and the byte stays on o_tx_data through WAIT_*.
  always_comb begin
    o_tx_start = 1'b0;
    o_tx_data  = '0;
    o_busy     = 1'b1;
    case (state_q)
      WAIT_A, WAIT_B, WAIT_OP: begin
        o_busy = 1'b0;
      end
      START_LO: begin
        o_tx_start = 1'b1;
        o_tx_data  = res_q[NB_DATA-1:0];
      end
      WAIT_LO: begin
        o_tx_data = res_q[NB_DATA-1:0];
      end
      START_HI: begin
        o_tx_start = 1'b1;
        o_tx_data  = {{(NB_DATA-1){1'b0}}, res_q[NB_DATA]};
      end
      WAIT_HI: begin
        o_tx_data = {{(NB_DATA-1){1'b0}}, res_q[NB_DATA]};
      end
      default: begin
        o_busy = 1'b1;
      end
    endcase
  end

  assign o_data_a = dataA_q;
  assign o_data_b = dataB_q;
  assign o_ops    = ops_q;

endmodule

// File: tb/tb_alu_uart_if.sv
// tb_alu_uart_if: directed bench for alu_uart_if. A transaction-level model
// (operand slots, a queue of bytes still to be returned, a busy flag) runs
// beside the DUT and a single compare process checks it every cycle; a few
// hand-computed literals pin the model. Honours ALU_IF_CARRY_BYTE_EN.
module tb_alu_uart_if;

  localparam int NB_DATA = 8;
  localparam int NB_OPS  = 6;

  localparam int SEL_LAST  = 0;
  localparam int SEL_A     = 1;
  localparam int SEL_B     = 2;
  localparam int SEL_OPS   = 3;
  localparam int SEL_START = 4;
  localparam int SEL_BUSY  = 5;
  localparam int SEL_TXD   = 6;

  logic               i_clk = 1'b0;
  logic               i_reset = 1'b1;
  logic [NB_DATA-1:0] i_rx_data = '0;
  logic               i_rx_done = 1'b0;
  logic               i_tx_done = 1'b0;
  logic               o_tx_start;
  logic [NB_DATA-1:0] o_tx_data;
  logic [NB_DATA-1:0] o_data_a;
  logic [NB_DATA-1:0] o_data_b;
  logic [NB_OPS-1:0]  o_ops;
  logic [NB_DATA:0]   i_alu_res;
  logic               o_busy;

  // Model state
  logic [7:0] mA = '0, mB = '0, mCurByte = '0;
  logic [5:0] mOps = '0;
  logic       mBusy = 1'b0, mStartNow = 1'b0, mInWait = 1'b0;
  logic       mExecPending = 1'b0, mTxHold = 1'b0;
  int         mSlot = 0;
  logic [7:0] mExpQ[$];
  logic       busyBefore, wasStart, newStart;
  logic [8:0] mRes;

  // Compare bookkeeping
  int          errCount = 0;
  int          checkCount = 0;
  logic        cmpEn = 1'b0;
  logic [7:0]  lastTxByte = '0;
  int          pinSeq = 0, pinDone = 0, pinSel = 0;
  logic [31:0] pinExp = '0, pinAct;
  string       pinName = "";

  alu_uart_if #(.NB_DATA(NB_DATA), .NB_OPS(NB_OPS)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_rx_data  (i_rx_data),
    .i_rx_done  (i_rx_done),
    .i_tx_done  (i_tx_done),
    .o_tx_start (o_tx_start),
    .o_tx_data  (o_tx_data),
    .o_data_a   (o_data_a),
    .o_data_b   (o_data_b),
    .o_ops      (o_ops),
    .i_alu_res  (i_alu_res),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Reference ALU: a few MIPS-style function codes, result is {carry,res}.
  function automatic logic [8:0] aluRef(input logic [7:0] a, input logic [7:0] b,
                                        input logic [5:0] op);
    case (op)
      6'h20:   return {1'b0, a} + {1'b0, b};
      6'h22:   return {1'b0, a} - {1'b0, b};
      6'h24:   return {1'b0, a & b};
      6'h25:   return {1'b0, a | b};
      6'h26:   return {1'b0, a ^ b};
      default: return 9'h000;
    endcase
  endfunction

  // The combinational ALU that sits next to the DUT in the real top level.
  assign i_alu_res = aluRef(o_data_a, o_data_b, o_ops);

  // Transaction model: three bytes fill the slots, the opcode queues the
  // bytes to return, the first byte starts two cycles after the opcode and
  // each further byte starts on the tx_done of the previous one.
  always @(posedge i_clk) begin
    if (i_reset) begin
      mA = '0; mB = '0; mOps = '0; mCurByte = '0;
      mBusy = 1'b0; mStartNow = 1'b0; mInWait = 1'b0;
      mExecPending = 1'b0; mTxHold = 1'b0; mSlot = 0;
      mExpQ.delete();
    end else begin
      busyBefore = mBusy;
      wasStart   = mStartNow;
      newStart   = 1'b0;
      if (i_tx_done && mInWait) begin
        mInWait = 1'b0;
        if (mExpQ.size() > 0) newStart = 1'b1;
        else begin
          mBusy   = 1'b0;
          mTxHold = 1'b0;
        end
      end
      if (wasStart) mInWait = 1'b1;
      if (mExecPending) begin
        mExecPending = 1'b0;
        newStart     = 1'b1;
      end
      if (i_rx_done && !busyBefore) begin
        if (mSlot == 0) begin
          mA = i_rx_data; mSlot = 1;
        end else if (mSlot == 1) begin
          mB = i_rx_data; mSlot = 2;
        end else begin
          mOps  = i_rx_data[5:0];
          mSlot = 0;
          mRes  = aluRef(mA, mB, mOps);
          mExpQ.push_back(mRes[7:0]);
`ifdef ALU_IF_CARRY_BYTE_EN
          mExpQ.push_back({7'b0, mRes[8]});
`endif
          mBusy        = 1'b1;
          mExecPending = 1'b1;
        end
      end
      if (newStart && mExpQ.size() > 0) begin
        mCurByte = mExpQ.pop_front();
        mTxHold  = 1'b1;
      end
      mStartNow = newStart;
    end
  end

  task automatic score(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process: model vs DUT each cycle, plus posted literal pins.
  always @(negedge i_clk) begin
    if (cmpEn) begin
      score("busy", {31'b0, o_busy}, {31'b0, mBusy});
      score("txStart", {31'b0, o_tx_start}, {31'b0, mStartNow});
      score("dataA", {24'b0, o_data_a}, {24'b0, mA});
      score("dataB", {24'b0, o_data_b}, {24'b0, mB});
      score("ops", {26'b0, o_ops}, {26'b0, mOps});
      if (mTxHold) score("txData", {24'b0, o_tx_data}, {24'b0, mCurByte});
      if (pinSeq != pinDone) begin
        case (pinSel)
          SEL_LAST:  pinAct = {24'b0, lastTxByte};
          SEL_A:     pinAct = {24'b0, o_data_a};
          SEL_B:     pinAct = {24'b0, o_data_b};
          SEL_OPS:   pinAct = {26'b0, o_ops};
          SEL_START: pinAct = {31'b0, o_tx_start};
          SEL_BUSY:  pinAct = {31'b0, o_busy};
          default:   pinAct = {24'b0, o_tx_data};
        endcase
        score(pinName, pinAct, pinExp);
        pinDone = pinSeq;
      end
      if (o_tx_start) lastTxByte = o_tx_data;
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge i_clk);
    #1;
  endtask

  // One-cycle pulse on rx_done and/or tx_done.
  task automatic applyStimulus(input logic rx, input logic tx, input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = rx;
    i_tx_done = tx;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rx_done = 1'b0;
    i_tx_done = 1'b0;
    #1;
  endtask

  task automatic applyReset();
    i_reset = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    #1;
  endtask

  // Posts a literal expectation, evaluated by the compare process next negedge.
  task automatic checkOutput(input string name, input int sel, input logic [31:0] exp);
    pinName = name;
    pinSel  = sel;
    pinExp  = exp;
    pinSeq++;
    @(negedge i_clk);
    #1;
  endtask

  task automatic sendOp(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    applyStimulus(1'b1, 1'b0, a);
    applyStimulus(1'b1, 1'b0, b);
    applyStimulus(1'b1, 1'b0, op);
  endtask

  // Called right after the opcode: pins the start latency and returned bytes.
  task automatic finishOp(input logic [7:0] lo, input logic [7:0] hi);
    checkOutput("startTwoAfterOp", SEL_START, 32'd1);
    checkOutput("txLoByte", SEL_LAST, {24'b0, lo});
    applyStimulus(1'b0, 1'b1, 8'h00);
`ifdef ALU_IF_CARRY_BYTE_EN
    checkOutput("txHiByte", SEL_LAST, {24'b0, hi});
    applyStimulus(1'b0, 1'b1, 8'h00);
`else
    checkOutput("noHiByteIdle", SEL_BUSY, {31'b0, hi[0] & 1'b0});
`endif
    waitCycles(1);
  endtask

  initial begin
    $display("[TB] start");
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    cmpEn   = 1'b1;
    #1;
    checkOutput("resetBusy", SEL_BUSY, 32'd0);
    checkOutput("resetTxData", SEL_TXD, 32'd0);
    checkOutput("resetDataA", SEL_A, 32'd0);

    // 1: ADD 5+3
    sendOp(8'h05, 8'h03, 8'h20);
    finishOp(8'h08, 8'h00);
    checkOutput("t1Ops", SEL_OPS, 32'h20);

    // 2: ADD with carry out
    sendOp(8'hFF, 8'h01, 8'h20);
    finishOp(8'h00, 8'h01);

    // 3: SUB through an opcode byte with upper bits set
    sendOp(8'h03, 8'h05, 8'hA2);
    finishOp(8'hFE, 8'h01);
    checkOutput("t3OpsMasked", SEL_OPS, 32'h22);
    checkOutput("t3KeepB", SEL_B, 32'h05);

    // 4: byte during WAIT_*, then rx+tx in the same cycle
    sendOp(8'h40, 8'h02, 8'h20);
    waitCycles(2);
    checkOutput("t4LoByte", SEL_LAST, 32'h42);
    applyStimulus(1'b1, 1'b0, 8'h77);
`ifdef ALU_IF_CARRY_BYTE_EN
    applyStimulus(1'b0, 1'b1, 8'h00);
    waitCycles(1);
`endif
    applyStimulus(1'b1, 1'b1, 8'h99);
    checkOutput("t4DroppedA", SEL_A, 32'h40);
    applyStimulus(1'b1, 1'b0, 8'h11);
    checkOutput("t4NewA", SEL_A, 32'h11);
    applyStimulus(1'b1, 1'b0, 8'h22);
    applyStimulus(1'b1, 1'b0, 8'h25);
    finishOp(8'h33, 8'h00);

    // 5: reset with a partial operand set, then AND
    applyStimulus(1'b1, 1'b0, 8'h10);
    applyStimulus(1'b1, 1'b0, 8'h20);
    applyReset();
    checkOutput("t5ResetA", SEL_A, 32'd0);
    checkOutput("t5ResetB", SEL_B, 32'd0);
    sendOp(8'h01, 8'h02, 8'h24);
    finishOp(8'h00, 8'h00);

    // 6: stray tx_done while idle
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("t6IdleStart", SEL_START, 32'd0);
    checkOutput("t6IdleBusy", SEL_BUSY, 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h07);
    checkOutput("t6FirstIsA", SEL_A, 32'h07);
    applyStimulus(1'b1, 1'b0, 8'h02);
    applyStimulus(1'b1, 1'b0, 8'h22);
    finishOp(8'h05, 8'h00);

    // Reset in the middle of a transmission
    sendOp(8'h0F, 8'h01, 8'h20);
    waitCycles(2);
    applyReset();
    checkOutput("midTxResetBusy", SEL_BUSY, 32'd0);
    checkOutput("midTxResetData", SEL_TXD, 32'd0);

    // XOR after recovery
    sendOp(8'hA5, 8'h5A, 8'h26);
    finishOp(8'hFF, 8'h00);

    waitCycles(2);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
